// File: rtl/quiz_pkg.sv
// Shared types, widths and helpers for the quiz buzzer arbiter.
package quiz_pkg;

  localparam int unsigned KEY_W = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned BCD_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_FOUL    = 3'd4
  } state_e;

  // Highest-numbered set bit of an active-high pressed mask.
  function automatic logic [IDX_W-1:0] prio_enc(input logic [KEY_W-1:0] act);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      if (act[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // 5-bit binary to two BCD digits {tens, units}.
  function automatic logic [2*BCD_W-1:0] bin5_to_bcd(input logic [4:0] v);
    logic [BCD_W-1:0] hi;
    logic [BCD_W-1:0] lo;
    hi = BCD_W'(v / 5'd10);
    lo = BCD_W'(v % 5'd10);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/quiz_tick_gen.sv
// Countdown prescaler: one-cycle tick every TICK_DIV enabled cycles.
module quiz_tick_gen #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == TERM);

  // Next prescaler value: clear wins, then wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/quiz_arbiter.sv
// Quiz buzzer arbiter: arms a countdown, locks the first (highest) key,
// flags early presses as fouls and drives buzzer and BCD display.
module quiz_arbiter
  import quiz_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned ANSWER_SEC = 9,
  parameter int unsigned BUZZ_CYC   = 100
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CLEAR,
  input  logic [KEY_W-1:0] Key,
  output logic [2:0]       State,
  output logic [IDX_W-1:0] Winner,
  output logic             WinValid,
  output logic             Foul,
  output logic             Buzz,
  output logic [BCD_W-1:0] DispHi,
  output logic [BCD_W-1:0] DispLo,
  output logic             DispBlank
);

  localparam int unsigned BW = $clog2(BUZZ_CYC + 1);
  localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYC);
  localparam logic [3:0]    CNT_LOAD  = 4'(ANSWER_SEC);

  logic [KEY_W-1:0] key_s1_q, key_s2_q;
  state_e           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic             valid_q, valid_d;
  logic [BW-1:0]    buzz_q, buzz_d;
  logic             press, tick;
  logic [IDX_W-1:0] idx;
  logic [2*BCD_W-1:0] win_bcd;

  assign press   = ~&key_s2_q;
  assign idx     = prio_enc(~key_s2_q);
  assign win_bcd = bin5_to_bcd({1'b0, winner_q} + 5'd1);

  quiz_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (state_q != ST_ARMED),
    .en_i   (state_q == ST_ARMED),
    .tick_o (tick)
  );

  // Two-flop synchronizer for the asynchronous active-low keys.
  always_ff @(posedge CLK) begin
    if (RST) begin
      key_s1_q <= '1;
      key_s2_q <= '1;
    end else begin
      key_s1_q <= Key;
      key_s2_q <= key_s1_q;
    end
  end

  // Next-state logic; a press in the same cycle as the final tick still wins.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    winner_d = winner_q;
    valid_d  = valid_q;
    buzz_d   = (buzz_q != '0) ? buzz_q - 1'b1 : '0;
    if (CLEAR) begin
      state_d  = ST_IDLE;
      count_d  = '0;
      winner_d = '0;
      valid_d  = 1'b0;
      buzz_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (press) begin
            state_d  = ST_FOUL;
            winner_d = idx;
            valid_d  = 1'b1;
            buzz_d   = BUZZ_LOAD;
          end else if (START) begin
            state_d = ST_ARMED;
            count_d = CNT_LOAD;
          end
        end
        ST_ARMED: begin
          if (press) begin
            state_d  = ST_LOCKED;
            winner_d = idx;
            valid_d  = 1'b1;
            buzz_d   = BUZZ_LOAD;
          end else if (tick) begin
            count_d = count_q - 1'b1;
            if (count_q == 4'd1) begin
              state_d = ST_TIMEOUT;
              buzz_d  = BUZZ_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      winner_q <= '0;
      valid_q  <= 1'b0;
      buzz_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      winner_q <= winner_d;
      valid_q  <= valid_d;
      buzz_q   <= buzz_d;
    end
  end

  // Display selection from registered state.
  always_comb begin
    DispBlank = 1'b0;
    DispHi    = '0;
    DispLo    = '0;
    unique case (state_q)
      ST_ARMED, ST_TIMEOUT: DispLo = count_q;
      ST_LOCKED, ST_FOUL:   {DispHi, DispLo} = win_bcd;
      default:              DispBlank = 1'b1;
    endcase
  end

  assign State    = state_q;
  assign Winner   = winner_q;
  assign WinValid = valid_q;
  assign Foul     = (state_q == ST_FOUL);
  assign Buzz     = (buzz_q != '0);

endmodule

// File: tb/tb_quiz_arbiter.sv
// Randomized and directed bench for quiz_arbiter against a cycle-level
// behavioural model.
module tb_quiz_arbiter;

  localparam int TICK   = 4;
  localparam int ANSWER = 9;
  localparam int BUZZ   = 3;

  localparam int S_IDLE = 0, S_ARMED = 1, S_LOCKED = 2, S_TIMEOUT = 3, S_FOUL = 4;

  logic        CLK = 1'b0;
  logic        RST, START, CLEAR;
  logic [15:0] Key;
  logic [2:0]  State;
  logic [3:0]  Winner, DispHi, DispLo;
  logic        WinValid, Foul, Buzz, DispBlank;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int          m_state, m_count, m_elapsed, m_winner, m_buzz;
  bit          m_valid;
  logic [15:0] hist0, hist1;

  quiz_arbiter #(.TICK_DIV(TICK), .ANSWER_SEC(ANSWER), .BUZZ_CYC(BUZZ)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CLEAR(CLEAR), .Key(Key),
    .State(State), .Winner(Winner), .WinValid(WinValid), .Foul(Foul),
    .Buzz(Buzz), .DispHi(DispHi), .DispLo(DispLo), .DispBlank(DispBlank)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Key seen by the arbiter at an edge is the Key sampled two edges earlier.
  task automatic model_step(input bit rst, input bit start, input bit clear, input logic [15:0] key);
    logic [15:0] eff;
    int          idx;
    bit          press;
    if (rst) begin
      m_state = S_IDLE; m_count = 0; m_elapsed = 0; m_winner = 0;
      m_valid = 0; m_buzz = 0; hist0 = '1; hist1 = '1;
      return;
    end
    eff   = hist1;
    hist1 = hist0;
    hist0 = key;
    press = (eff != 16'hFFFF);
    idx   = 0;
    for (int i = 0; i < 16; i++) if (!eff[i]) idx = i;
    if (m_buzz > 0) m_buzz--;
    if (clear) begin
      m_state = S_IDLE; m_winner = 0; m_valid = 0; m_buzz = 0;
    end else begin
      case (m_state)
        S_IDLE: begin
          if (press) begin
            m_state = S_FOUL; m_winner = idx; m_valid = 1; m_buzz = BUZZ;
          end else if (start) begin
            m_state = S_ARMED; m_elapsed = 0; m_count = ANSWER;
          end
        end
        S_ARMED: begin
          if (press) begin
            m_state = S_LOCKED; m_winner = idx; m_valid = 1; m_buzz = BUZZ;
          end else begin
            m_elapsed++;
            m_count = ANSWER - m_elapsed / TICK;
            if (m_count == 0) begin
              m_state = S_TIMEOUT; m_buzz = BUZZ;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    int eh, el, eb;
    if (m_state == S_IDLE) begin
      eb = 1; eh = 0; el = 0;
    end else if (m_state == S_ARMED || m_state == S_TIMEOUT) begin
      eb = 0; eh = 0; el = m_count;
    end else begin
      eb = 0; eh = (m_winner + 1) / 10; el = (m_winner + 1) % 10;
    end
    check("State",     32'(State),     m_state);
    check("Winner",    32'(Winner),    m_winner);
    check("WinValid",  32'(WinValid),  32'(m_valid));
    check("Foul",      32'(Foul),      (m_state == S_FOUL) ? 1 : 0);
    check("Buzz",      32'(Buzz),      (m_buzz > 0) ? 1 : 0);
    check("DispBlank", 32'(DispBlank), eb);
    check("DispHi",    32'(DispHi),    eh);
    check("DispLo",    32'(DispLo),    el);
  endtask

  task automatic cycle(input bit rst, input bit start, input bit clear, input logic [15:0] key);
    @(negedge CLK);
    RST = rst; START = start; CLEAR = clear; Key = key;
    @(posedge CLK);
    model_step(rst, start, clear, key);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 16'hFFFF);
  endtask

  initial begin
    int          nb, cyc;
    logic [15:0] k;
    int          pct, clr_pct;

    RST = 1; START = 0; CLEAR = 0; Key = 16'hFFFF;
    cycle(1, 0, 0, 16'hFFFF);
    check("rst_state", 32'(State), S_IDLE);
    check("rst_blank", 32'(DispBlank), 1);
    idle(2);

    // Single winner, Key[5]
    cycle(0, 1, 0, 16'hFFFF);
    cycle(0, 0, 0, ~(16'h1 << 5));
    idle(2);
    check("k5_state", 32'(State), S_LOCKED);
    check("k5_winner", 32'(Winner), 5);
    check("k5_disp", 32'({DispHi, DispLo}), 32'h06);
    nb = Buzz ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (Buzz) nb++;
    end
    check("k5_buzz_len", nb, BUZZ);

    // Simultaneous Key[3] and Key[12]
    cycle(0, 0, 1, 16'hFFFF);
    cycle(0, 1, 0, 16'hFFFF);
    cycle(0, 0, 0, ~(16'h1 << 3) & ~(16'h1 << 12));
    idle(2);
    check("k12_winner", 32'(Winner), 12);
    check("k12_disp", 32'({DispHi, DispLo}), 32'h13);

    // Timeout with no press
    cycle(0, 0, 1, 16'hFFFF);
    cycle(0, 1, 0, 16'hFFFF);
    check("to_start_cnt", 32'(DispLo), ANSWER);
    cyc = 0;
    while (State != 3'(S_TIMEOUT) && cyc < 100) begin
      idle(1);
      cyc++;
    end
    check("to_cycles", cyc, ANSWER * TICK);
    check("to_valid", 32'(WinValid), 0);
    check("to_disp", 32'(DispLo), 0);

    // Foul in IDLE on Key[0]
    cycle(0, 0, 1, 16'hFFFF);
    cycle(0, 0, 0, 16'hFFFE);
    idle(2);
    check("foul_flag", 32'(Foul), 1);
    check("foul_disp", 32'({DispHi, DispLo}), 32'h01);
    cycle(0, 1, 0, 16'hFFFF);
    check("foul_hold", 32'(State), S_FOUL);
    cycle(0, 0, 1, 16'hFFFF);
    check("foul_clear", 32'(State), S_IDLE);
    check("foul_clear_blank", 32'(DispBlank), 1);

    // Press effective on the edge the count would reach 0
    cycle(0, 1, 0, 16'hFFFF);
    idle(ANSWER * TICK - 3);
    cycle(0, 0, 0, ~(16'h1 << 7));
    idle(2);
    check("last_tick_state", 32'(State), S_LOCKED);
    check("last_tick_winner", 32'(Winner), 7);

    // Reset mid-countdown, then mid-buzz
    cycle(0, 0, 1, 16'hFFFF);
    cycle(0, 1, 0, 16'hFFFF);
    idle(10);
    cycle(1, 1, 1, 16'h0000);
    check("rst_mid_cnt", 32'(State), S_IDLE);
    check("rst_mid_cnt_blank", 32'(DispBlank), 1);
    cycle(0, 1, 0, 16'hFFFF);
    cycle(0, 0, 0, 16'hFF7F);
    idle(3);
    cycle(1, 0, 0, 16'hFF7F);
    check("rst_mid_buzz", 32'(Buzz), 0);
    check("rst_mid_buzz_valid", 32'(WinValid), 0);
    idle(3);
    check("rst_sync_flushed", 32'(State), S_IDLE);

    // Random phases: busy, then sparse presses to reach timeouts
    for (int n = 0; n < 3000; n++) begin
      pct     = (n < 1500) ? 8 : 1;
      clr_pct = (n < 1500) ? 5 : 2;
      k = 16'hFFFF;
      if ($urandom_range(0, 99) < pct) begin
        k = k & ~(16'h1 << $urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) k = k & ~(16'h1 << $urandom_range(0, 15));
      end
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 99) < clr_pct, k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/quiz_arbiter.md
QUIZ_ARBITER -- requirements
Module: quiz_arbiter

Interface
REQ-001 Parameter TICK_DIV, 1000, CLK cycles per countdown tick (>=2).
REQ-002 Parameter ANSWER_SEC, 9, countdown start value in ticks (1..9).
REQ-003 Parameter BUZZ_CYC, 100, buzzer pulse length in CLK cycles (>=1).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 START  input  1  host arm request, sampled each cycle, level-sensitive.
REQ-007 CLEAR  input  1  host return-to-idle request, sampled each cycle.
REQ-008 Key  input  16  contestant buttons, active-low, asynchronous; Key[15] highest priority.
REQ-009 State  output  3  current FSM state code.
REQ-010 Winner  output  4  latched index of winning or fouling key.
REQ-011 WinValid  output  1  high while Winner holds a latched index.
REQ-012 Foul  output  1  high in FOUL state.
REQ-013 Buzz  output  1  buzzer drive pulse.
REQ-014 DispHi, DispLo  output  4 each  BCD tens/units digits for external 4511 decoders.
REQ-015 DispBlank  output  1  high = blank both digits (drives 4511 BI active-low externally inverted).

Function
REQ-016 Key SHALL pass a 2-flop synchronizer; "press" = any synchronized bit low.
REQ-017 Encoded index SHALL be the highest-numbered low synchronized bit (16-line priority encode).
REQ-018 States: IDLE, ARMED, LOCKED, TIMEOUT, FOUL.
REQ-019 IDLE: START -> ARMED, count loaded with ANSWER_SEC, prescaler cleared; press (without START) -> FOUL with index latched.
REQ-020 IDLE with START and press in same cycle SHALL go to FOUL.
REQ-021 ARMED: prescaler counts 0..TICK_DIV-1; at terminal value count decrements by 1.
REQ-022 ARMED: press -> LOCKED, Winner latched, count frozen.
REQ-023 ARMED: tick taking count to 0 -> TIMEOUT; press in same cycle SHALL win (LOCKED).
REQ-024 LOCKED, TIMEOUT, FOUL SHALL hold until CLEAR; START and Key ignored.
REQ-025 CLEAR in any state -> IDLE next edge; CLEAR has priority over START and press.
REQ-026 Latency: Key sampled low at edge k -> State/Winner/WinValid updated at edge k+2.
REQ-027 WinValid/Winner SHALL be set on entry to LOCKED or FOUL and cleared on entry to IDLE.
REQ-028 Buzz SHALL be high exactly BUZZ_CYC cycles starting the edge LOCKED, FOUL or TIMEOUT is entered; CLEAR truncates it.
REQ-029 Display: IDLE blank; ARMED/TIMEOUT show count (DispHi=0); LOCKED/FOUL show Winner+1 as two BCD digits (1..16).
REQ-030 Winner+1 conversion SHALL be 5-bit binary to BCD; values 10..16 give DispHi=1.

Reset
REQ-031 RST SHALL force: State=IDLE, Winner=0, WinValid=0, Foul=0, Buzz=0, count=0, prescaler=0, synchronizer flops=1, DispBlank=1, DispHi=DispLo=0.
REQ-032 RST SHALL take priority over CLEAR, START and Key in the same cycle, including mid-countdown and mid-buzz.

Structure
REQ-033 Shared package quiz_pkg SHALL hold state encoding (IDLE=0, ARMED=1, LOCKED=2, TIMEOUT=3, FOUL=4) and widths (KEY_W=16, IDX_W=4, BCD_W=4).
REQ-034 Sub-module quiz_tick_gen SHALL implement the TICK_DIV prescaler with clear and enable inputs and a one-cycle tick output.

Verification (TICK_DIV=4, ANSWER_SEC=9, BUZZ_CYC=3)
REQ-035 START, then Key[5] low -> LOCKED, Winner=5, WinValid=1, DispHi=0, DispLo=6, Buzz 3 cycles.
REQ-036 START, Key[3] and Key[12] low same cycle -> Winner=12, DispHi=1, DispLo=3.
REQ-037 START, no press -> count 9..0 one step per 4 cycles, TIMEOUT after 36 cycles, Buzz 3 cycles, WinValid=0.
REQ-038 Key[0] low in IDLE -> FOUL, Foul=1, Winner=0, display 0/1; START ignored; CLEAR -> IDLE, blank.
REQ-039 Press on the cycle count reaches 0 -> LOCKED, not TIMEOUT.
REQ-040 RST asserted mid-countdown and mid-buzz -> all outputs at REQ-031 values next edge.
